reg_serializer: RTL and testbench

//   Read side of the parallel register path: captures a WIDTH-bit word on a

---
 rtl/serializer_pkg.sv | 15 +
 rtl/ser_shift_reg.sv | 27 ++
 rtl/reg_serializer.sv | 114 +++++++++++
 tb/tb_reg_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the register-path serializer.
// The PAR state is only reachable when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit load/shift-left register; load wins over shift, msb is the bit on the wire.
module ser_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/reg_serializer.sv
// Parallel-load, MSB-first serializer with valid/ready on both sides.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module reg_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a stalled beat holds its value.
  ser_state_e    state, state_next;
  logic [CW-1:0] cnt;
  logic          load, shift, msb, done_next;
`ifdef SERIALIZER_PARITY_EN
  logic          par_bit;
`endif

  ser_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (data),
    .msb   (msb)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          shift = 1'b1;
          if (cnt == '0) begin
`ifdef SERIALIZER_PARITY_EN
            state_next = PAR;
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PAR: begin
        if (sout_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      // Counter saturates at zero so a stray shift can never wrap it.
      if (load) begin
        cnt <= CW'(WIDTH - 1);
      end else if (shift && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef SERIALIZER_PARITY_EN
  // Parity is taken from the word at capture time, before any shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= ^data;
    end
  end

  assign sout_valid = (state == SHIFT) || (state == PAR);
  assign sout       = (state == SHIFT) ? msb : ((state == PAR) ? par_bit : 1'b0);
`else
  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) ? msb : 1'b0;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_reg_serializer.sv
// Randomized bench for reg_serializer: expected bit stream built from the word
// (MSB first, plus even parity when SERIALIZER_PARITY_EN is defined).
module tb_reg_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];

  reg_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .busy       (busy),
    .done       (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic void build_model(input logic [W-1:0] w);
    exp_q.delete();
    for (int k = 0; k < W; k++) exp_q.push_back(w[W-1-k]);
`ifdef SERIALIZER_PARITY_EN
    exp_q.push_back(^w);
`endif
  endfunction

  // Sends one word and follows it to done. mode 0: always ready,
  // mode 1: random stalls, mode 2: three stall cycles once bit 1 is accepted.
  // offer: keep offering 8'hFF while the word is in flight.
  task automatic run_word(input logic [W-1:0] w, input int mode, input bit offer);
    int   idx;
    int   cycles;
    int   stalls;
    bit   got_done;
    bit   r;
    logic exp_bit;
    in_valid   = 1'b1;
    data       = w;
    sout_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL accept: in_ready=%b required 1", in_ready);
    else n_pass++;
    build_model(w);
    @(negedge clk);
    in_valid = offer;
    data     = offer ? {W{1'b1}} : W'($urandom);
    idx      = 0;
    cycles   = 1;
    stalls   = 0;
    got_done = 1'b0;
    while (!got_done && cycles < 200) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        in_valid = 1'b0;
        n_checks++;
        if ({idx, sout_valid} !== {NB, 1'b0})
          $display("FAIL done_point: bits=%0d sout_valid=%b required bits=%0d sout_valid=0",
                   idx, sout_valid, NB);
        else n_pass++;
        if (mode == 0) begin
          n_checks++;
          if (cycles !== NB + 1)
            $display("FAIL latency: done in cycle %0d required %0d", cycles, NB + 1);
          else n_pass++;
        end
      end else begin
        n_checks++;
        if ({in_ready, busy} !== 2'b01)
          $display("FAIL busy_flags: in_ready=%b busy=%b required 0 1", in_ready, busy);
        else n_pass++;
        exp_bit = (idx < NB) ? exp_q[idx] : 1'b0;
        n_checks++;
        if (idx >= NB)
          $display("FAIL overrun: bit %0d seen, word has only %0d", idx, NB);
        else if ({sout_valid, sout} !== {1'b1, exp_bit})
          $display("FAIL bit%0d of %h: sout_valid=%b sout=%b required 1 %b",
                   idx, w, sout_valid, sout, exp_bit);
        else n_pass++;
        case (mode)
          0: r = 1'b1;
          1: r = ($urandom_range(0, 2) != 0);
          default: begin
            if (idx == 2 && stalls < 3) begin
              r = 1'b0;
              stalls++;
            end else r = 1'b1;
          end
        endcase
        sout_ready = r;
        if (r) idx++;
        @(negedge clk);
        cycles++;
      end
    end
    if (!got_done) begin
      n_checks++;
      $display("FAIL timeout: no done for word %h after %0d cycles", w, cycles);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset(input int hold);
    rst        = 1'b1;
    in_valid   = 1'b0;
    sout_ready = 1'b0;
    data       = '0;
    repeat (hold) @(negedge clk);
    n_checks++;
    if ({sout_valid, sout, busy, done, in_ready} !== 5'b00001)
      $display("FAIL reset_hold: sv=%b s=%b busy=%b done=%b in_ready=%b required 0 0 0 0 1",
               sout_valid, sout, busy, done, in_ready);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sout_valid, busy, done, in_ready} !== 4'b0001)
      $display("FAIL reset_release: sv=%b busy=%b done=%b in_ready=%b required 0 0 0 1",
               sout_valid, busy, done, in_ready);
    else n_pass++;
  endtask

  task automatic test_pattern_aa();
    run_word(8'hAA, 0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_pulse: done=%b one cycle later required 0", done);
    else n_pass++;
  endtask

  task automatic test_stall_55();
    run_word(8'h55, 2, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_word(8'hAA, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit seen_done;
    in_valid   = 1'b1;
    data       = 8'hF0;
    sout_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sout_valid, sout, busy, done, in_ready} !== 5'b00001)
      $display("FAIL mid_reset: sv=%b s=%b busy=%b done=%b in_ready=%b required 0 0 0 0 1",
               sout_valid, sout, busy, done, in_ready);
    else n_pass++;
    @(negedge clk);
    rst       = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) $display("FAIL abort_quiet: done/busy seen=1 after abort required 0");
    else n_pass++;
    run_word(8'h0F, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      run_word(W'($urandom), (i % 3 == 0) ? 0 : 1, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity();
    run_word(8'hAA, 0, 1'b0);
    run_word(8'h07, 0, 1'b0);
    @(negedge clk);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    sout_ready = 1'b0;
    data       = '0;
    @(negedge clk);
    test_reset(2);
    test_pattern_aa();
    test_stall_55();
    @(negedge clk);
    test_busy_ignore();
    @(negedge clk);
    test_mid_reset();
    @(negedge clk);
    test_back_to_back();
    test_reset(3);
`ifdef SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
